vc_qspi_mem: RTL

- Quad-SPI external memory controller behind the vc CPU core.
- Serves I-cache and D-cache line fills (burst reads) and single-word write-through stores.
- Drives the flash/PSRAM pins that the TinyTapeout top routes out through uio_in/uio_out/uio_oe.
- Talks to the cache arbiter through a req/ack request port and a per-word rvalid return stream.

---
 rtl/vc_qspi_mem.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/vc_qspi_mem.sv
// rtl/vc_qspi_mem.sv - Quad-SPI external memory controller: cache line burst reads and single-word writes
//
// Purpose: accepts one request at a time from the cache arbiter and runs a
// quad-SPI transaction: command, 24-bit address, optional dummy slots, then data.
// Every nibble slot lasts two clocks. In phase 0 sck is low and sd_out changes.
// In phase 1 sck is high, and read data is sampled on the edge that ends it.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   req/we/addr/wdata   request port; sampled on the accepting edge
//   ack                 one-cycle pulse on the accepting edge
//   busy                controller not idle
//   rdata/rvalid        returned read words, one rvalid pulse per word, in address order
//   done                one-cycle pulse when cs_n rises at the end of a transaction
//   cs_n/sck            memory chip select (active low) and SPI clock
//   sd_out/sd_oe/sd_in  quad data pins: output value, output enable, input
module vc_qspi_mem #(
    parameter int PA         = 24,
    parameter int LINE_WORDS = 4,
    parameter int DUMMY      = 4,
    parameter int CSH        = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          we,
    input  logic [PA-1:0] addr,
    input  logic [15:0]   wdata,
    output logic          ack,
    output logic          busy,
    output logic [15:0]   rdata,
    output logic          rvalid,
    output logic          done,
    output logic          cs_n,
    output logic          sck,
    output logic [3:0]    sd_out,
    output logic          sd_oe,
    input  logic [3:0]    sd_in
);
    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_DESEL} state_t;

    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY - 1);
    localparam logic [7:0] RD_LAST    = 8'(4 * LINE_WORDS - 1);
    localparam logic [7:0] CSH_LAST   = 8'(CSH - 1);

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cs_n_q, cs_n_d, sck_q, sck_d, sd_oe_q, sd_oe_d;
    logic [3:0]  sd_out_q, sd_out_d;
    logic        ack_q, ack_d, rvalid_q, rvalid_d, done_q, done_d;
    logic [15:0] rdata_q, rdata_d, wdata_q, wdata_d;
    logic [11:0] shift_q, shift_d;
    logic [23:0] addr_q, addr_d, addr_ext;
    logic        we_q, we_d;
    logic [7:0]  cmd;
    logic        slot_last;

    // The memory always sees a 24-bit address; narrower address spaces are zero-padded.
    if (PA >= 24) begin : g_addr_trunc
        assign addr_ext = addr[23:0];
    end else begin : g_addr_pad
        assign addr_ext = {{(24 - PA){1'b0}}, addr};
    end

    assign cmd = we_q ? 8'h38 : 8'hEB;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        sd_out_d  = sd_out_q;
        sd_oe_d   = sd_oe_q;
        ack_d     = 1'b0;
        rvalid_d  = 1'b0;
        done_d    = 1'b0;
        rdata_d   = rdata_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        slot_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    ack_d    = 1'b1;
                    addr_d   = addr_ext & 24'hFF_FFFE;
                    we_d     = we;
                    wdata_d  = wdata;
                    cs_n_d   = 1'b0;
                    sd_oe_d  = 1'b1;
                    // First command nibble goes out with the accept so slot 0 starts at once.
                    sd_out_d = we ? 4'h3 : 4'hE;
                    phase_d  = 1'b0;
                    cnt_d    = 8'd0;
                    state_d  = ST_CMD;
                end
            end
            ST_DESEL: begin
                if (cnt_q == CSH_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                if (!phase_q) begin
                    sck_d   = 1'b1;
                    phase_d = 1'b1;
                end else begin
                    sck_d   = 1'b0;
                    phase_d = 1'b0;
                    if (state_q == ST_DATA && !we_q) begin
                        shift_d = {shift_q[7:0], sd_in};
                        // Nibbles arrive byte0-hi, byte0-lo, byte1-hi, byte1-lo.
                        if (cnt_q[1:0] == 2'd3) begin
                            rvalid_d = 1'b1;
                            rdata_d  = {shift_q[3:0], sd_in, shift_q[11:8], shift_q[7:4]};
                        end
                    end
                    case (state_q)
                        ST_CMD:   slot_last = (cnt_q == 8'd1);
                        ST_ADDR:  slot_last = (cnt_q == 8'd5);
                        ST_DUMMY: slot_last = (cnt_q == DUMMY_LAST);
                        default:  slot_last = (cnt_q == (we_q ? 8'd3 : RD_LAST));
                    endcase
                    cnt_d = slot_last ? 8'd0 : cnt_q + 8'd1;
                    if (slot_last) begin
                        case (state_q)
                            ST_CMD:   state_d = ST_ADDR;
                            ST_ADDR:  state_d = (we_q || DUMMY == 0) ? ST_DATA : ST_DUMMY;
                            ST_DUMMY: state_d = ST_DATA;
                            default:  state_d = ST_DESEL;
                        endcase
                    end
                    // Load the nibble for the slot that starts now.
                    sd_out_d = 4'h0;
                    sd_oe_d  = 1'b1;
                    case (state_d)
                        ST_CMD: sd_out_d = cnt_d[0] ? cmd[3:0] : cmd[7:4];
                        ST_ADDR: begin
                            case (cnt_d[2:0])
                                3'd0:    sd_out_d = addr_q[23:20];
                                3'd1:    sd_out_d = addr_q[19:16];
                                3'd2:    sd_out_d = addr_q[15:12];
                                3'd3:    sd_out_d = addr_q[11:8];
                                3'd4:    sd_out_d = addr_q[7:4];
                                default: sd_out_d = addr_q[3:0];
                            endcase
                        end
                        ST_DATA: begin
                            if (we_q) begin
                                case (cnt_d[1:0])
                                    2'd0:    sd_out_d = wdata_q[7:4];
                                    2'd1:    sd_out_d = wdata_q[3:0];
                                    2'd2:    sd_out_d = wdata_q[15:12];
                                    default: sd_out_d = wdata_q[11:8];
                                endcase
                            end else begin
                                sd_oe_d = 1'b0;
                            end
                        end
                        ST_DESEL: begin
                            sd_oe_d = 1'b0;
                            cs_n_d  = 1'b1;
                            done_d  = 1'b1;
                        end
                        default: sd_oe_d = 1'b0;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            phase_q  <= 1'b0;
            cnt_q    <= 8'd0;
            cs_n_q   <= 1'b1;
            sck_q    <= 1'b0;
            sd_out_q <= 4'h0;
            sd_oe_q  <= 1'b0;
            ack_q    <= 1'b0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= 16'h0;
            shift_q  <= 12'h0;
            addr_q   <= 24'h0;
            we_q     <= 1'b0;
            wdata_q  <= 16'h0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            cs_n_q   <= cs_n_d;
            sck_q    <= sck_d;
            sd_out_q <= sd_out_d;
            sd_oe_q  <= sd_oe_d;
            ack_q    <= ack_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            shift_q  <= shift_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
        end
    end

    assign ack    = ack_q;
    assign busy   = (state_q != ST_IDLE);
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign done   = done_q;
    assign cs_n   = cs_n_q;
    assign sck    = sck_q;
    assign sd_out = sd_out_q;
    assign sd_oe  = sd_oe_q;
endmodule
